nx_fetch_arbiter: RTL and testbench
===================================

# nx_fetch_arbiter

Sequencer and arbiter for the no-execute permission check on the instruction-fetch path. It accepts fetch-permission requests from several fetch sources (demand fetch, prefetcher, …), sends one request at a time to the shared page-attribute lookup, and returns a per-request fault verdict. It also holds the first unacknowledged NX fault for the trap logic. It sits between the fetch units and the TLB attribute port.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters (≥2).
- ADDR_W, 64: fetch virtual-address width.
- CNT_W, 16: fault-counter width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_addr_i  in  NUM_REQ*ADDR_W  per-requester fetch address; requester k occupies bits [k*ADDR_W +: ADDR_W].
- req_ready_o  out  NUM_REQ  one-hot grant; the request transfers when valid and ready are both high.
- chk_valid_o  out  1  lookup request to the attribute port.
- chk_addr_o  out  ADDR_W  lookup address.
- chk_resp_valid_i  in  1  lookup result valid; latency is arbitrary, minimum 0 cycles.
- chk_nx_i  in  1  page is non-executable; qualified by chk_resp_valid_i.
- enforce_i  in  1  NX enforcement enable; sampled at request acceptance.
- resp_valid_o  out  1  verdict valid.
- resp_id_o  out  $clog2(NUM_REQ)  index of the requester that owns the verdict.
- resp_fault_o  out  1  NX fault for this request.
- resp_ready_i  in  1  verdict consumer ready.
- fault_valid_o  out  1  sticky fault record present.
- fault_addr_o  out  ADDR_W  address of the recorded fault.
- fault_id_o  out  $clog2(NUM_REQ)  requester of the recorded fault.
- fault_clear_i  in  1  clears the sticky fault record.
- fault_cnt_o  out  CNT_W  saturating fault count (see Configuration).

## Operation
- FSM with three states: IDLE → LOOKUP → RESP → IDLE. At most one request is outstanding.
- IDLE
  - req_ready_o is combinational: one-hot to the round-robin winner among the asserted req_valid_i; all zeros if no request is valid.
  - On transfer, latch the address, the requester id and enforce_i; move the round-robin pointer to winner+1 (mod NUM_REQ); go to LOOKUP.
- LOOKUP
  - chk_valid_o = 1 and chk_addr_o = latched address, held stable until chk_resp_valid_i.
  - On chk_resp_valid_i: verdict = enforce_q & chk_nx_i; go to RESP.
- RESP
  - resp_valid_o = 1; resp_id_o and resp_fault_o held stable.
  - On resp_ready_i, go to IDLE.
- Round-robin:
  - After reset the pointer is 0, so requester 0 has highest priority.
  - The search runs from the pointer upward with wrap-around.
- Sticky record:
  - On a faulting verdict (at LOOKUP exit) with fault_valid_o = 0, capture the address and id and set fault_valid_o.
  - Later faults do not overwrite the record while fault_valid_o = 1.
  - fault_clear_i clears fault_valid_o on the next edge.
  - If fault_clear_i coincides with a new fault, the new fault is captured (fault_valid_o stays 1 with the new address and id).
- chk_resp_valid_i outside LOOKUP is ignored.
- Output values while invalid:
  - chk_addr_o is don't-care while chk_valid_o = 0.
  - resp_id_o and resp_fault_o are driven 0 while resp_valid_o = 0.

## Timing
- Reset values:
  - State IDLE and pointer 0.
  - req_ready_o = 0 during the reset cycle.
  - chk_valid_o, resp_valid_o, resp_id_o, resp_fault_o, fault_valid_o = 0.
  - fault_addr_o, fault_id_o, fault_cnt_o = 0.
- Cycle sequence:
  - Transfer in cycle N → chk_valid_o high from N+1.
  - Response in cycle M → resp_valid_o high from M+1.
  - Minimum request-to-verdict latency is 2 cycles (zero-latency lookup).
- Minimum initiation interval is 3 cycles: IDLE, LOOKUP, RESP with resp_ready_i already high. The next transfer is in N+3.
- Reset in any state, including mid-LOOKUP or mid-RESP, aborts the transaction with no verdict. A lookup response arriving after reset is ignored.
- fault_cnt_o updates on the same edge as fault_valid_o capture.

## Configuration
- NX_FAULT_CNT_EN
  - Defined: fault_cnt_o increments by 1 on every faulting verdict, whether or not the sticky record is already occupied. It saturates at 2^CNT_W−1 and is cleared only by rst_i; fault_clear_i does not affect it.
  - Undefined: no counter register; fault_cnt_o is tied to 0.

## Test plan
- Single request, zero-latency lookup: req 0 at address 0x1000, enforce_i = 1, chk_nx_i = 0.
  - chk_valid_o in N+1.
  - resp_valid_o in N+2 with id 0 and fault 0.
  - fault_valid_o stays 0.
- NX fault with 3-cycle lookup: req 1 at address 0xDEAD_0000, chk_nx_i = 1.
  - resp_fault_o = 1.
  - fault_valid_o = 1, fault_addr_o = 0xDEAD_0000, fault_id_o = 1.
  - fault_cnt_o = 1 (NX_FAULT_CNT_EN defined).
- Contention: both requesters held valid for 4 transactions → grants in order 0, 1, 0, 1.
- Sticky and clear:
  - Second fault at 0x2000 while the record is set → record stays 0xDEAD_0000; count = 2.
  - fault_clear_i in the same cycle as a third fault at 0x3000 → record becomes 0x3000; count = 3.
- Backpressure and enforcement off:
  - resp_ready_i held low for 5 cycles → verdict stable and no new grant.
  - enforce_i = 0 with chk_nx_i = 1 → resp_fault_o = 0.
- Reset mid-LOOKUP:
  - rst_i in the second LOOKUP cycle → chk_valid_o = 0 the next cycle.
  - A late chk_resp_valid_i is ignored; no resp_valid_o is produced.
  - The pointer returns to 0.

Source files
------------

// File: rtl/nx_fetch_arbiter_if.sv
// Signal bundle between the fetch sources, the attribute-lookup port, the verdict
// consumer and the trap logic. The master modport is the arbiter's own view.
interface nx_fetch_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 64,
  parameter int CNT_W   = 16
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      chk_valid_o;
  logic [ADDR_W-1:0]         chk_addr_o;
  logic                      chk_resp_valid_i;
  logic                      chk_nx_i;
  logic                      enforce_i;
  logic                      resp_valid_o;
  logic [ID_W-1:0]           resp_id_o;
  logic                      resp_fault_o;
  logic                      resp_ready_i;
  logic                      fault_valid_o;
  logic [ADDR_W-1:0]         fault_addr_o;
  logic [ID_W-1:0]           fault_id_o;
  logic                      fault_clear_i;
  logic [CNT_W-1:0]          fault_cnt_o;

  modport master (
    input  req_valid_i, req_addr_i, chk_resp_valid_i, chk_nx_i, enforce_i,
           resp_ready_i, fault_clear_i,
    output req_ready_o, chk_valid_o, chk_addr_o, resp_valid_o, resp_id_o,
           resp_fault_o, fault_valid_o, fault_addr_o, fault_id_o, fault_cnt_o
  );

  modport slave (
    output req_valid_i, req_addr_i, chk_resp_valid_i, chk_nx_i, enforce_i,
           resp_ready_i, fault_clear_i,
    input  req_ready_o, chk_valid_o, chk_addr_o, resp_valid_o, resp_id_o,
           resp_fault_o, fault_valid_o, fault_addr_o, fault_id_o, fault_cnt_o
  );
endinterface

// File: rtl/nx_fetch_arbiter.sv
// Round-robin NX permission-check sequencer: one lookup outstanding, per-request verdict,
// sticky first-fault record. Define NX_FAULT_CNT_EN to build the saturating fault counter.
module nx_fetch_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 64,
  parameter int CNT_W   = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  nx_fetch_arbiter_if.master bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  state_t             state_reg, state_next;
  logic [ID_W-1:0]    ptr_reg, ptr_next;
  logic [ADDR_W-1:0]  addr_reg;
  logic [ID_W-1:0]    id_reg;
  logic               enf_reg;
  logic               verdict_reg;
  logic               fault_valid_reg;
  logic [ADDR_W-1:0]  fault_addr_reg;
  logic [ID_W-1:0]    fault_id_reg;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win_idx;
  logic               found;
  logic               take;
  logic               lookup_done;
  logic               new_fault;
  logic [ID_W:0]      sum;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign addr_arr[gi] = bus.req_addr_i[gi*ADDR_W +: ADDR_W];
    assign grant[gi]    = take && (win_idx == ID_W'(gi));
  end

  // Search upward from the pointer, wrapping; sum never exceeds 2*NUM_REQ-2.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    sum     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_reg} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      if (!found && bus.req_valid_i[sum[ID_W-1:0]]) begin
        found   = 1'b1;
        win_idx = sum[ID_W-1:0];
      end
    end
  end

  assign ptr_next    = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + ID_W'(1);
  assign take        = (state_reg == IDLE) && found && !rst_i;
  assign lookup_done = (state_reg == LOOKUP) && bus.chk_resp_valid_i;
  assign new_fault   = lookup_done && enf_reg && bus.chk_nx_i;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (take) state_next = LOOKUP;
      LOOKUP:  if (bus.chk_resp_valid_i) state_next = RESP;
      RESP:    if (bus.resp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_reg         <= '0;
      addr_reg        <= '0;
      id_reg          <= '0;
      enf_reg         <= 1'b0;
      verdict_reg     <= 1'b0;
      fault_valid_reg <= 1'b0;
      fault_addr_reg  <= '0;
      fault_id_reg    <= '0;
    end else begin
      if (take) begin
        addr_reg <= addr_arr[win_idx];
        id_reg   <= win_idx;
        enf_reg  <= bus.enforce_i;
        ptr_reg  <= ptr_next;
      end
      if (lookup_done) verdict_reg <= enf_reg & bus.chk_nx_i;
      // A fault arriving with a clear replaces the old record rather than being lost.
      if (new_fault && (!fault_valid_reg || bus.fault_clear_i)) begin
        fault_valid_reg <= 1'b1;
        fault_addr_reg  <= addr_reg;
        fault_id_reg    <= id_reg;
      end else if (bus.fault_clear_i) begin
        fault_valid_reg <= 1'b0;
      end
    end
  end

`ifdef NX_FAULT_CNT_EN
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_reg <= '0;
    else if (new_fault && (cnt_reg != {CNT_W{1'b1}})) cnt_reg <= cnt_reg + CNT_W'(1);
  end

  assign bus.fault_cnt_o = cnt_reg;
`else
  assign bus.fault_cnt_o = {CNT_W{1'b0}};
`endif

  assign bus.req_ready_o   = grant;
  assign bus.chk_valid_o   = (state_reg == LOOKUP);
  assign bus.chk_addr_o    = addr_reg;
  assign bus.resp_valid_o  = (state_reg == RESP);
  assign bus.resp_id_o     = (state_reg == RESP) ? id_reg : '0;
  assign bus.resp_fault_o  = (state_reg == RESP) ? verdict_reg : 1'b0;
  assign bus.fault_valid_o = fault_valid_reg;
  assign bus.fault_addr_o  = fault_addr_reg;
  assign bus.fault_id_o    = fault_id_reg;
endmodule

// File: tb/tb_nx_fetch_arbiter.sv
// Directed and randomized bench for nx_fetch_arbiter against a transaction-level model
// (rotating priority, verdict = enforce & nx, first-fault record, saturating count).
module tb_nx_fetch_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 64;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int          m_ptr   = 0;
  logic        m_fv    = 1'b0;
  logic [63:0] m_faddr = '0;
  int          m_fid   = 0;
  int          m_cnt   = 0;

  logic [ADDR_W-1:0] addr_tb [NUM_REQ];

  nx_fetch_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  nx_fetch_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt();
`ifdef NX_FAULT_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic chk_record(input string tag);
    chk({tag, "_fault_valid"}, 64'(bus.fault_valid_o), 64'(m_fv));
    if (m_fv) begin
      chk({tag, "_fault_addr"}, bus.fault_addr_o, m_faddr);
      chk({tag, "_fault_id"}, 64'(bus.fault_id_o), 64'(m_fid));
    end
    chk({tag, "_fault_cnt"}, 64'(bus.fault_cnt_o), 64'(exp_cnt()));
  endtask

  // One complete transaction starting in IDLE, #1 after a rising edge.
  // lat = LOOKUP cycles before the response; bp = RESP cycles with resp_ready low.
  task automatic txn(input logic [NUM_REQ-1:0] vmask, input logic enf, input int lat,
                     input logic nx, input int bp, input logic clr);
    int win;
    int k;
    logic [NUM_REQ-1:0] exp_gnt;
    logic [63:0] exp_addr;
    logic verdict;
    win = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (m_ptr + i) % NUM_REQ;
      if (win < 0 && vmask[k]) win = k;
    end
    exp_gnt = '0;
    exp_gnt[win] = 1'b1;
    exp_addr = addr_tb[win];
    for (int r = 0; r < NUM_REQ; r++) bus.req_addr_i[r*ADDR_W +: ADDR_W] = addr_tb[r];
    bus.req_valid_i = vmask;
    bus.enforce_i   = enf;
    @(negedge clk);
    chk("grant", 64'(bus.req_ready_o), 64'(exp_gnt));
    chk("idle_chk_valid", 64'(bus.chk_valid_o), 64'd0);
    chk("idle_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("idle_resp_id", 64'(bus.resp_id_o), 64'd0);
    chk("idle_resp_fault", 64'(bus.resp_fault_o), 64'd0);
    @(posedge clk); #1;
    m_ptr = (win + 1) % NUM_REQ;
    bus.enforce_i = ~enf;
    for (int c = 0; c <= lat; c++) begin
      if (c == lat) begin
        bus.chk_resp_valid_i = 1'b1;
        bus.chk_nx_i         = nx;
        bus.fault_clear_i    = clr;
      end else begin
        bus.chk_resp_valid_i = 1'b0;
        bus.chk_nx_i         = 1'($urandom);
      end
      @(negedge clk);
      chk("lookup_chk_valid", 64'(bus.chk_valid_o), 64'd1);
      chk("lookup_chk_addr", bus.chk_addr_o, exp_addr);
      chk("lookup_no_grant", 64'(bus.req_ready_o), 64'd0);
      chk("lookup_resp_valid", 64'(bus.resp_valid_o), 64'd0);
      @(posedge clk); #1;
    end
    bus.fault_clear_i = 1'b0;
    verdict = enf & nx;
    if (verdict) begin
      if (!m_fv || clr) begin
        m_fv = 1'b1;
        m_faddr = exp_addr;
        m_fid = win;
      end
      if (m_cnt < CNT_MAX) m_cnt++;
    end else if (clr) begin
      m_fv = 1'b0;
    end
    for (int c = 0; c <= bp; c++) begin
      bus.resp_ready_i     = (c == bp);
      bus.chk_resp_valid_i = 1'($urandom);
      bus.chk_nx_i         = 1'($urandom);
      @(negedge clk);
      chk("resp_valid", 64'(bus.resp_valid_o), 64'd1);
      chk("resp_id", 64'(bus.resp_id_o), 64'(win));
      chk("resp_fault", 64'(bus.resp_fault_o), 64'(verdict));
      chk("resp_chk_valid", 64'(bus.chk_valid_o), 64'd0);
      chk("resp_no_grant", 64'(bus.req_ready_o), 64'd0);
      chk_record("resp");
      @(posedge clk); #1;
    end
    bus.resp_ready_i     = 1'b0;
    bus.chk_resp_valid_i = 1'b0;
    bus.req_valid_i      = '0;
    $display("txn req=%0d addr=%0h enf=%0b nx=%0b lat=%0d bp=%0d clr=%0b fault=%0b rec=%0b cnt=%0d",
             win, exp_addr, enf, nx, lat, bp, clr, verdict, m_fv, exp_cnt());
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid_i      = '1;
    bus.req_addr_i       = '0;
    bus.chk_resp_valid_i = 1'b0;
    bus.chk_nx_i         = 1'b0;
    bus.enforce_i        = 1'b1;
    bus.resp_ready_i     = 1'b0;
    bus.fault_clear_i    = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) addr_tb[r] = '0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst_chk_valid", 64'(bus.chk_valid_o), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("rst_resp_id", 64'(bus.resp_id_o), 64'd0);
    chk("rst_resp_fault", 64'(bus.resp_fault_o), 64'd0);
    chk("rst_fault_valid", 64'(bus.fault_valid_o), 64'd0);
    chk("rst_fault_addr", bus.fault_addr_o, 64'd0);
    chk("rst_fault_id", 64'(bus.fault_id_o), 64'd0);
    chk("rst_fault_cnt", 64'(bus.fault_cnt_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid_i = '0;

    // Single request, zero-latency lookup, no fault
    addr_tb[0] = 64'h1000;
    txn(2'b01, 1'b1, 0, 1'b0, 0, 1'b0);

    // NX fault from requester 1 after a 3-cycle lookup
    addr_tb[1] = 64'hDEAD_0000;
    txn(2'b10, 1'b1, 3, 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("nx_fault_addr", bus.fault_addr_o, 64'hDEAD_0000);
    chk("nx_fault_id", 64'(bus.fault_id_o), 64'd1);
    @(posedge clk); #1;

    // Contention: both requesters valid for four transactions
    for (int t = 0; t < 4; t++) begin
      addr_tb[0] = {$urandom, $urandom};
      addr_tb[1] = {$urandom, $urandom};
      txn(2'b11, 1'b1, t % 2, 1'b0, 0, 1'b0);
    end

    // Second fault does not overwrite the record
    addr_tb[0] = 64'h2000;
    txn(2'b01, 1'b1, 1, 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("sticky_keep_addr", bus.fault_addr_o, 64'hDEAD_0000);
    @(posedge clk); #1;

    // Clear coinciding with a third fault captures the new one
    addr_tb[1] = 64'h3000;
    txn(2'b10, 1'b1, 0, 1'b1, 0, 1'b1);
    @(negedge clk);
    chk("clear_recapture_addr", bus.fault_addr_o, 64'h3000);
    chk("clear_recapture_valid", 64'(bus.fault_valid_o), 64'd1);
    @(posedge clk); #1;

    // Backpressure with enforcement off and nx set
    addr_tb[0] = 64'h4000;
    addr_tb[1] = 64'h5000;
    txn(2'b11, 1'b0, 2, 1'b1, 5, 1'b0);

    // Plain clear with no coinciding fault
    addr_tb[1] = 64'h6000;
    txn(2'b10, 1'b1, 1, 1'b0, 1, 1'b1);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      addr_tb[0] = {$urandom, $urandom};
      addr_tb[1] = {$urandom, $urandom};
      txn(2'($urandom_range(1, 3)), 1'($urandom), $urandom_range(0, 3), 1'($urandom),
          $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end

    // Reset in the second LOOKUP cycle aborts the transaction
    addr_tb[0] = 64'h7000;
    bus.req_addr_i[0 +: ADDR_W] = addr_tb[0];
    bus.req_valid_i = 2'b01;
    bus.enforce_i   = 1'b1;
    @(negedge clk);
    chk("abort_grant", 64'(bus.req_ready_o), 64'd1);
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    @(negedge clk);
    chk("abort_lookup1", 64'(bus.chk_valid_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = 0; m_fv = 1'b0; m_faddr = '0; m_fid = 0; m_cnt = 0;
    bus.chk_resp_valid_i = 1'b1;
    bus.chk_nx_i         = 1'b1;
    bus.resp_ready_i     = 1'b1;
    @(negedge clk);
    chk("abort_chk_valid", 64'(bus.chk_valid_o), 64'd0);
    chk("abort_resp_valid0", 64'(bus.resp_valid_o), 64'd0);
    @(posedge clk); #1;
    bus.chk_resp_valid_i = 1'b0;
    bus.resp_ready_i     = 1'b0;
    @(negedge clk);
    chk("abort_resp_valid1", 64'(bus.resp_valid_o), 64'd0);
    chk_record("abort");
    @(posedge clk); #1;
    bus.req_valid_i = 2'b11;
    @(negedge clk);
    chk("abort_ptr_zero", 64'(bus.req_ready_o), 64'd1);
    $display("txn reset-abort req=0 addr=7000");
    @(posedge clk); #1;
    bus.req_valid_i = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
